// File: rtl/alu_tp1_pkg.sv
// Shared opcode encodings (MIPS R-type funct) and default widths for the TP1 ALU.
// Optional flag outputs are enabled by defining ALU_TP1_FLAGS_EN.
package alu_tp1_pkg;

    localparam int DEF_NB_DATA = 8;
    localparam int DEF_NB_OP   = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_tp1_comb.sv
// Combinational opcode decode and compute for the TP1 ALU.
// With ALU_TP1_FLAGS_EN defined, also produces zero/carry/overflow flags.
module alu_tp1_comb
    import alu_tp1_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_OP   = DEF_NB_OP
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [NB_OP-1:0]   op,
    output logic [NB_DATA-1:0] res
`ifdef ALU_TP1_FLAGS_EN
    ,
    output logic               zero,
    output logic               carry,
    output logic               ovf
`endif
);

    localparam logic [NB_OP-1:0] C_ADD = NB_OP'(OP_ADD);
    localparam logic [NB_OP-1:0] C_SUB = NB_OP'(OP_SUB);
    localparam logic [NB_OP-1:0] C_AND = NB_OP'(OP_AND);
    localparam logic [NB_OP-1:0] C_OR  = NB_OP'(OP_OR);
    localparam logic [NB_OP-1:0] C_XOR = NB_OP'(OP_XOR);
    localparam logic [NB_OP-1:0] C_NOR = NB_OP'(OP_NOR);
    localparam logic [NB_OP-1:0] C_SRA = NB_OP'(OP_SRA);
    localparam logic [NB_OP-1:0] C_SRL = NB_OP'(OP_SRL);
    localparam logic [NB_DATA:0] SHIFT_LIM = (NB_DATA + 1)'(NB_DATA);
    localparam int MSB = NB_DATA - 1;

    logic [NB_DATA-1:0] add_r;
    logic [NB_DATA-1:0] sub_r;
    logic               shift_big;

    assign add_r     = a + b;
    assign sub_r     = a - b;
    // The whole of b is the shift amount, so anything >= width saturates.
    assign shift_big = {1'b0, b} >= SHIFT_LIM;

    always_comb begin
        res = '0;
        case (op)
            C_ADD: res = add_r;
            C_SUB: res = sub_r;
            C_AND: res = a & b;
            C_OR:  res = a | b;
            C_XOR: res = a ^ b;
            C_NOR: res = ~(a | b);
            C_SRA: res = shift_big ? {NB_DATA{a[MSB]}} : NB_DATA'($signed(a) >>> b);
            C_SRL: res = shift_big ? '0 : (a >> b);
            default: res = '0;
        endcase
    end

`ifdef ALU_TP1_FLAGS_EN
    logic [NB_DATA:0] add_w;
    logic [NB_DATA:0] sub_w;

    // SUB carry is the carry-out of a + ~b + 1, i.e. set when no borrow occurs.
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} + {1'b0, ~b} + (NB_DATA + 1)'(1);
    assign zero  = (res == '0);

    always_comb begin
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            C_ADD: begin
                carry = add_w[NB_DATA];
                ovf   = (a[MSB] == b[MSB]) && (add_r[MSB] != a[MSB]);
            end
            C_SUB: begin
                carry = sub_w[NB_DATA];
                ovf   = (a[MSB] != b[MSB]) && (sub_r[MSB] != a[MSB]);
            end
            default: begin
                carry = 1'b0;
                ovf   = 1'b0;
            end
        endcase
    end
`endif

endmodule

// File: rtl/alu_tp1_core.sv
// TP1 ALU top: registers the combinational result (1-cycle latency, async active-low reset).
// Define ALU_TP1_FLAGS_EN to add registered o_ZERO/o_CARRY/o_OVF outputs.
module alu_tp1_core
    import alu_tp1_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_OP   = DEF_NB_OP
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_A,
    input  logic [NB_DATA-1:0] i_B,
    input  logic [NB_OP-1:0]   i_OP,
    output logic [NB_DATA-1:0] o_RES
`ifdef ALU_TP1_FLAGS_EN
    ,
    output logic               o_ZERO,
    output logic               o_CARRY,
    output logic               o_OVF
`endif
);

    logic [NB_DATA-1:0] res_next;

`ifdef ALU_TP1_FLAGS_EN
    logic zero_next;
    logic carry_next;
    logic ovf_next;

    alu_tp1_comb #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_comb (
        .a     (i_A),
        .b     (i_B),
        .op    (i_OP),
        .res   (res_next),
        .zero  (zero_next),
        .carry (carry_next),
        .ovf   (ovf_next)
    );

    // Flags clear with the result so nothing from before reset leaks out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_RES   <= '0;
            o_ZERO  <= 1'b0;
            o_CARRY <= 1'b0;
            o_OVF   <= 1'b0;
        end else begin
            o_RES   <= res_next;
            o_ZERO  <= zero_next;
            o_CARRY <= carry_next;
            o_OVF   <= ovf_next;
        end
    end
`else
    alu_tp1_comb #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_comb (
        .a   (i_A),
        .b   (i_B),
        .op  (i_OP),
        .res (res_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_RES <= '0;
        end else begin
            o_RES <= res_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_tp1_core.sv
// Self-checking bench for alu_tp1_core: directed literal cases, reset behaviour and
// randomized operations compared every cycle against an integer-arithmetic model.
module tb_alu_tp1_core;
    import alu_tp1_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
`ifdef ALU_TP1_FLAGS_EN
    logic       zero_f;
    logic       carry_f;
    logic       ovf_f;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    alu_tp1_core #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_A     (a),
        .i_B     (b),
        .i_OP    (op),
        .o_RES   (res)
`ifdef ALU_TP1_FLAGS_EN
        ,
        .o_ZERO  (zero_f),
        .o_CARRY (carry_f),
        .o_OVF   (ovf_f)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: plain integer arithmetic on 8-bit values
    function automatic int model_res(int av, int bv, logic [5:0] o);
        int sa;
        case (o)
            OP_ADD: return (av + bv) % 256;
            OP_SUB: return (av - bv + 256) % 256;
            OP_AND: return av & bv;
            OP_OR:  return av | bv;
            OP_XOR: return av ^ bv;
            OP_NOR: return 255 - (av | bv);
            OP_SRL: return (bv >= 8) ? 0 : (av / (1 << bv));
            OP_SRA: begin
                sa = (av >= 128) ? av - 256 : av;
                if (bv >= 8) return (sa < 0) ? 255 : 0;
                sa = sa >>> bv;
                return (sa + 256) % 256;
            end
            default: return 0;
        endcase
    endfunction

    function automatic int to_signed8(int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int model_carry(int av, int bv, logic [5:0] o);
        if (o == OP_ADD) return (av + bv > 255) ? 1 : 0;
        if (o == OP_SUB) return (av >= bv) ? 1 : 0;
        return 0;
    endfunction

    function automatic int model_ovf(int av, int bv, logic [5:0] o);
        int s;
        if (o == OP_ADD) s = to_signed8(av) + to_signed8(bv);
        else if (o == OP_SUB) s = to_signed8(av) - to_signed8(bv);
        else return 0;
        return (s > 127 || s < -128) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // scoreboard: expected outputs queued at each sampling edge, popped at the next negedge
    logic [7:0] exp_q[$];
    logic [2:0] expf_q[$];
    bit         scoreboard_on = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            expf_q.delete();
        end else if (scoreboard_on) begin
            exp_q.push_back(8'(model_res(int'(a), int'(b), op)));
            expf_q.push_back({1'(model_res(int'(a), int'(b), op) == 0),
                              1'(model_carry(int'(a), int'(b), op)),
                              1'(model_ovf(int'(a), int'(b), op))});
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        logic [2:0] ef;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ef = expf_q.pop_front();
            check("rand_res", int'(res), int'(e));
`ifdef ALU_TP1_FLAGS_EN
            check("rand_zero",  int'(zero_f),  int'(ef[2]));
            check("rand_carry", int'(carry_f), int'(ef[1]));
            check("rand_ovf",   int'(ovf_f),   int'(ef[0]));
`else
            if (ef === 3'bxxx) check("rand_flags_x", 1, 0);
`endif
        end
    end

    // driver: change inputs just after a falling edge, then check after the sampling edge
    task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic [5:0] o);
        @(negedge clk);
        #1;
        a  = av;
        b  = bv;
        op = o;
    endtask

    task automatic directed(input string name, input logic [7:0] av, input logic [7:0] bv,
                            input logic [5:0] o, input logic [7:0] exp);
        check({name, "_model"}, model_res(int'(av), int'(bv), o), int'(exp));
        drive(av, bv, o);
        @(posedge clk);
        #1;
        check(name, int'(res), int'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        op    = OP_ADD;
        #1;
        check("reset_res", int'(res), 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", int'(res), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        directed("add_01_00", 8'h01, 8'h00, OP_ADD, 8'h01);
        directed("add_06_01", 8'h06, 8'h01, OP_ADD, 8'h07);
        directed("add_wrap",  8'h80, 8'hFF, OP_ADD, 8'h7F);
`ifdef ALU_TP1_FLAGS_EN
        check("wrap_carry", int'(carry_f), 1);
        check("wrap_ovf",   int'(ovf_f),   1);
        check("wrap_zero",  int'(zero_f),  0);
`endif
        check("wrap_carry_model", model_carry(8'h80, 8'hFF, OP_ADD), 1);
        check("wrap_ovf_model",   model_ovf(8'h80, 8'hFF, OP_ADD),   1);
        directed("sub_0f_05", 8'h0F, 8'h05, OP_SUB, 8'h0A);
        directed("sub_30_96", 8'h30, 8'h96, OP_SUB, 8'h9A);
        directed("and_8f_aa", 8'h8F, 8'hAA, OP_AND, 8'h8A);
        directed("and_fa_b3", 8'hFA, 8'hB3, OP_AND, 8'hB2);
        directed("or_8f_aa",  8'h8F, 8'hAA, OP_OR,  8'hAF);
        directed("xor_8f_aa", 8'h8F, 8'hAA, OP_XOR, 8'h25);
        directed("nor_00_00", 8'h00, 8'h00, OP_NOR, 8'hFF);
        directed("sra_80_02", 8'h80, 8'h02, OP_SRA, 8'hE0);
        directed("sra_80_09", 8'h80, 8'h09, OP_SRA, 8'hFF);
        directed("sra_40_ff", 8'h40, 8'hFF, OP_SRA, 8'h00);
        directed("srl_80_02", 8'h80, 8'h02, OP_SRL, 8'h20);
        directed("srl_80_09", 8'h80, 8'h09, OP_SRL, 8'h00);
        directed("srl_ff_07", 8'hFF, 8'h07, OP_SRL, 8'h01);
        directed("op_3f",     8'h12, 8'h34, 6'b111111, 8'h00);

        // reset arriving mid-cycle clears at once and drops the operation in flight
        directed("pre_reset", 8'h06, 8'h01, OP_ADD, 8'h07);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", int'(res), 0);
        @(posedge clk);
        #1;
        check("reset_held_edge", int'(res), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset", int'(res), 8'h07);

        // randomized traffic checked by the scoreboard every cycle
        begin
            logic [5:0] ops [9];
            ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL, 6'b000000};
            @(negedge clk);
            #1;
            scoreboard_on = 1'b1;
            for (int i = 0; i < 400; i++) begin
                a = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
                else b = 8'($urandom_range(0, 10));
                if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
                else op = ops[$urandom_range(0, 8)];
                @(negedge clk);
                #1;
            end
            scoreboard_on = 1'b0;
            repeat (2) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/alu_tp1_core.md
ALU_TP1_CORE -- requirements
Module: alu_tp1_core

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, operand and result width.
REQ-002 SHALL have parameter NB_OP, default 6, opcode width.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_A  input  NB_DATA  operand A.
REQ-006 SHALL have port i_B  input  NB_DATA  operand B.
REQ-007 SHALL have port i_OP  input  NB_OP  operation select, MIPS R-type funct encoding.
REQ-008 SHALL have port o_RES  output  NB_DATA  registered result.

Function
REQ-009 SHALL decode i_OP as follows: 100000 ADD A+B; 100010 SUB A-B; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR ~(A|B); 000011 SRA A>>>B; 000010 SRL A>>B.
REQ-010 SHALL compute ADD/SUB modulo 2^NB_DATA with two's-complement wrap-around; negative SUB results appear in two's complement.
REQ-011 SHALL use the full unsigned value of i_B as shift amount; for amount >= NB_DATA, SRL yields 0 and SRA yields all copies of A's MSB.
REQ-012 SHALL produce o_RES = 0 for any unlisted opcode.
REQ-013 SHALL register the result: o_RES reflects inputs sampled at a rising edge of i_clk, valid after that edge (latency 1 cycle, throughput 1 op/cycle).
REQ-014 SHALL have no handshake; inputs are sampled unconditionally every cycle.
REQ-015 SHALL treat operands as unsigned for all ops except SRA (signed A).

Reset
REQ-016 SHALL clear o_RES (and all flags, when compiled in) to 0 immediately on i_rst_n low, independent of i_clk.
REQ-017 SHALL hold outputs at 0 while i_rst_n is low; first valid result appears at the first rising edge after deassertion.
REQ-018 SHALL discard any operation in flight when reset asserts mid-operation.

Configuration
REQ-019 SHALL, when macro ALU_TP1_FLAGS_EN is defined, add registered outputs o_ZERO (result == 0), o_CARRY (ADD carry-out / SUB borrow-free carry, 0 for other ops) and o_OVF (signed overflow for ADD/SUB, 0 otherwise), same latency as o_RES.
REQ-020 SHALL, without ALU_TP1_FLAGS_EN, omit these ports and their logic entirely.

Structure
REQ-021 SHALL place opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL) and default widths in shared package alu_tp1_pkg.
REQ-022 SHALL implement combinational decode/compute in sub-module alu_tp1_comb; alu_tp1_core adds only the output registers and reset.

Verification
REQ-023 ADD: A=01,B=00 -> o_RES=01; A=06,B=01 -> 07, each one cycle after sampling edge.
REQ-024 ADD wrap: A=80,B=FF -> o_RES=7F; with flags, o_CARRY=1, o_OVF=1, o_ZERO=0.
REQ-025 SUB: A=0F,B=05 -> 0A; A=30,B=96 -> 9A (two's complement of -102).
REQ-026 AND: A=8F,B=AA -> 8A; A=FA,B=B3 -> B2; OR of 8F,AA -> AF; NOR of 00,00 -> FF.
REQ-027 Shifts/default: SRA A=80,B=02 -> E0; SRL A=80,B=02 -> 20; SRL B=09 -> 00; i_OP=111111 -> 00.
REQ-028 Reset: drive ADD 06+01, assert i_rst_n low between edges -> o_RES=00 at once; release -> 07 after next edge.
